flow_table_wr_arbiter: RTL

- Shares the flow table's 32-bit serial write port between two requesters: req0 is the PS/AXI4-lite config path and req1 is the PL flow-learning path.
- Accepts one complete flow entry per grant: address, 128-bit key, id and valid bit.
- Serialises each entry into the five-beat write sequence the flow table expects, paced by its wdone pulse.
- Sits between the requesters and the flow table write port. Reports per-entry completion and error status.

---
 rtl/flow_table_wr_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/flow_table_wr_arbiter.sv
// Arbitrates two flow-entry writers onto the flow table's five-beat serial write port.
// Define FT_WR_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module flow_table_wr_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int ID_W     = 16,
    parameter int WDONE_TO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [127:0]      req0_key,
    input  logic [ID_W-1:0]   req0_id,
    input  logic              req0_ent_valid,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [127:0]      req1_key,
    input  logic [ID_W-1:0]   req1_id,
    input  logic              req1_ent_valid,
    output logic [ADDR_W-1:0] ft_waddr,
    output logic [31:0]       ft_wdata,
    output logic              ft_we,
    input  logic              ft_wdone,
    output logic              done,
    output logic              done_src,
    output logic              done_err,
    output logic              busy,
    output logic              err_to,
    output logic              err_stray,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(WDONE_TO + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               src_q, src_d;
    logic [2:0]         beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               derr_q, derr_d;
    logic               err_to_q, err_to_d;
    logic               err_stray_q, err_stray_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [127:0]       key_q;
    logic [ID_W-1:0]    id_q;
    logic               ev_q;
    logic               grant0, grant1, acc0, acc1, load, set_to;

    // Valid/ready: an entry transfers on a cycle with reqN_valid & reqN_ready. Ready is
    // offered only in IDLE and only to the arbitration winner; a requester keeps its
    // payload stable while valid & !ready, and may withdraw valid before ready.
`ifdef FT_WR_ARB_RR_EN
    logic last_q;

    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= src_d;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = (state_q == S_IDLE) & grant0;
    assign req1_ready = (state_q == S_IDLE) & grant1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        derr_d  = derr_q;
        load    = 1'b0;
        set_to  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc0 | acc1) begin
                    load    = 1'b1;
                    src_d   = acc1;
                    beat_d  = 3'd0;
                    derr_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ft_wdone) begin
                    if (beat_q == 3'd4) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Abandon the rest of the entry; the flow table needs a reset to realign.
                    if (cnt_q == CNT_W'(WDONE_TO - 1)) begin
                        set_to  = 1'b1;
                        derr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err_to_d    = err_clr ? 1'b0 : (err_to_q | set_to);
    assign err_stray_d = err_clr ? 1'b0 : (err_stray_q | (ft_wdone & (state_q != S_WAIT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= 1'b0;
            beat_q      <= 3'd0;
            cnt_q       <= '0;
            derr_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_stray_q <= 1'b0;
            addr_q      <= '0;
            key_q       <= '0;
            id_q        <= '0;
            ev_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            derr_q      <= derr_d;
            err_to_q    <= err_to_d;
            err_stray_q <= err_stray_d;
            if (load) begin
                addr_q <= acc1 ? req1_addr      : req0_addr;
                key_q  <= acc1 ? req1_key       : req0_key;
                id_q   <= acc1 ? req1_id        : req0_id;
                ev_q   <= acc1 ? req1_ent_valid : req0_ent_valid;
            end
        end
    end

    always_comb begin
        ft_wdata = '0;
        if (state_q == S_ISSUE) begin
            case (beat_q)
                3'd0:    ft_wdata = key_q[31:0];
                3'd1:    ft_wdata = key_q[63:32];
                3'd2:    ft_wdata = key_q[95:64];
                3'd3:    ft_wdata = key_q[127:96];
                default: ft_wdata[ID_W:0] = {ev_q, id_q};
            endcase
        end
    end

    assign ft_we     = (state_q == S_ISSUE);
    assign ft_waddr  = (state_q != S_IDLE) ? addr_q : '0;
    assign done      = (state_q == S_DONE);
    assign done_src  = done & src_q;
    assign done_err  = done & derr_q;
    assign busy      = (state_q != S_IDLE);
    assign err_to    = err_to_q;
    assign err_stray = err_stray_q;
    assign dbg_state = state_q;

endmodule
